ucpd_bmc_tx: RTL and testbench

Digital BMC transmitter for the UCPD block. It drives the PHY transmit pins cc_datao and cc_dataoen, and sends one complete USB-PD frame per request: preamble, SOP ordered set, 4b5b-encoded payload bytes, EOP and line tail. Payload bytes arrive from the UCPD TX data path through a valid/ready handshake. CRC bytes are generated upstream and sent here as ordinary payload.

---
 rtl/ucpd_pkg.sv | 50 +++++
 rtl/ucpd_4b5b_enc.sv | 11 +
 rtl/ucpd_bmc_tx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ucpd_bmc_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucpd_pkg.sv
// Shared definitions for the UCPD BMC transmitter: line-code tables,
// K-codes, FSM encoding and counter widths.
package ucpd_pkg;

   localparam logic [4:0] K_SYNC1 = 5'b11000;
   localparam logic [4:0] K_SYNC2 = 5'b10001;
   localparam logic [4:0] K_SYNC3 = 5'b00110;
   localparam logic [4:0] K_RST1  = 5'b00111;
   localparam logic [4:0] K_RST2  = 5'b11001;
   localparam logic [4:0] K_EOP   = 5'b01101;

   localparam int PRE_CNT_W = 7;
   localparam int SOP_CNT_W = 5;
   localparam int SOP_BITS  = 20;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SOP      = 3'd2,
      ST_DATA     = 3'd3,
      ST_EOP      = 3'd4,
      ST_TAIL     = 3'd5
   } tx_state_t;

   // USB-PD 4b5b data symbols; bit 0 of the result goes on the line first
   function automatic logic [4:0] enc4b5b(input logic [3:0] nibble);
      logic [4:0] sym;
      case (nibble)
         4'h0:    sym = 5'b11110;
         4'h1:    sym = 5'b01001;
         4'h2:    sym = 5'b10100;
         4'h3:    sym = 5'b10101;
         4'h4:    sym = 5'b01010;
         4'h5:    sym = 5'b01011;
         4'h6:    sym = 5'b01110;
         4'h7:    sym = 5'b01111;
         4'h8:    sym = 5'b10010;
         4'h9:    sym = 5'b10011;
         4'hA:    sym = 5'b10110;
         4'hB:    sym = 5'b10111;
         4'hC:    sym = 5'b11010;
         4'hD:    sym = 5'b11011;
         4'hE:    sym = 5'b11100;
         4'hF:    sym = 5'b11101;
         default: sym = 5'b11110;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/ucpd_4b5b_enc.sv
// Combinational 4b5b encoder feeding the transmitter's symbol shifter.
module ucpd_4b5b_enc
   import ucpd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [4:0] symbol
);

   assign symbol = enc4b5b(nibble);

endmodule

// File: rtl/ucpd_bmc_tx.sv
// UCPD BMC transmitter: preamble, SOP, 4b5b payload, EOP and tail,
// driven onto cc_datao/cc_dataoen with a programmable half-bit period.
module ucpd_bmc_tx
   import ucpd_pkg::*;
#(
   parameter int PRE_BITS = 64,
   parameter int TAIL_HB  = 2,
   parameter int DIV_W    = 8
) (
   input  logic             ucpd_clk,
   input  logic             ucpd_rstn,
   input  logic [DIV_W-1:0] hbit_div,
   input  logic             tx_start,
   input  logic [19:0]      tx_sop,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   input  logic             tx_last,
   output logic             tx_ready,
   input  logic             tx_abort,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             tx_underrun,
   output logic             cc_datao,
   output logic             cc_dataoen
);

   localparam logic [PRE_CNT_W-1:0] PRE_LAST  = PRE_CNT_W'(PRE_BITS - 1);
   localparam logic [PRE_CNT_W-1:0] SOP_LAST  = PRE_CNT_W'(SOP_BITS - 1);
   localparam logic [PRE_CNT_W-1:0] TAIL_LAST = PRE_CNT_W'(TAIL_HB - 1);

   tx_state_t              state_r, state_s;
   logic [DIV_W-1:0]       cnt_r, cnt_s, div_r, div_s;
   logic                   half_r, half_s;
   logic [PRE_CNT_W-1:0]   bit_r, bit_s;
   logic [19:0]            sh_r, sh_s;
   logic [3:0]             nib_hi_r, nib_hi_s;
   logic [7:0]             hold_r, hold_s;
   logic                   hold_last_r, hold_last_s, hold_full_r, hold_full_s;
   logic                   last_in_r, last_in_s;
   logic                   under_r, under_s;
   logic                   datao_r, datao_s, oen_r, oen_s, busy_r, busy_s;
   logic                   ready_r, ready_s, done_r, done_s, under_p_r, under_p_s;
   logic                   tick_s, take_s, avail_s, cur_bit_s, bnd_s, byte_last_s;
   logic [7:0]             byte_s;
   logic [3:0]             nib_s;
   logic [4:0]             sym_s;

   assign tick_s      = (cnt_r == {DIV_W{1'b0}});
   assign take_s      = tx_valid & ready_r;
   // A byte offered in the boundary cycle itself is forwarded straight to the shifter
   assign avail_s     = hold_full_r | take_s;
   assign byte_s      = hold_full_r ? hold_r : tx_data;
   assign byte_last_s = hold_full_r ? hold_last_r : tx_last;
   assign cur_bit_s   = (state_r == ST_PREAMBLE) ? bit_r[0] : sh_r[0];
   assign nib_s       = ((state_r == ST_DATA) && (bit_r == 7'd4)) ? nib_hi_r : byte_s[3:0];

   ucpd_4b5b_enc u_enc (
      .nibble (nib_s),
      .symbol (sym_s)
   );

   // Next-state, line coding and byte handoff
   always_comb begin
      state_s     = state_r;
      div_s       = div_r;
      half_s      = half_r;
      bit_s       = bit_r;
      sh_s        = sh_r;
      nib_hi_s    = nib_hi_r;
      hold_s      = hold_r;
      hold_last_s = hold_last_r;
      hold_full_s = hold_full_r;
      last_in_s   = last_in_r;
      under_s     = under_r;
      datao_s     = datao_r;
      oen_s       = oen_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      under_p_s   = 1'b0;
      bnd_s       = 1'b0;
      cnt_s       = tick_s ? div_r : (cnt_r - DIV_W'(1));

      if (take_s) begin
         hold_s      = tx_data;
         hold_last_s = tx_last;
         hold_full_s = 1'b1;
      end else begin
         hold_full_s = hold_full_r;
      end

      case (state_r)
         ST_IDLE: begin
            cnt_s = cnt_r;
            if (tx_start && !tx_abort) begin
               state_s     = ST_PREAMBLE;
               cnt_s       = hbit_div;
               div_s       = hbit_div;
               half_s      = 1'b0;
               bit_s       = 7'd0;
               sh_s        = tx_sop;
               last_in_s   = 1'b0;
               under_s     = 1'b0;
               hold_full_s = 1'b0;
               hold_last_s = 1'b0;
               datao_s     = 1'b1;
               oen_s       = 1'b1;
               busy_s      = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_TAIL: begin
            datao_s = 1'b0;
            if (tick_s && (bit_r == TAIL_LAST)) begin
               state_s     = ST_IDLE;
               bit_s       = 7'd0;
               oen_s       = 1'b0;
               busy_s      = 1'b0;
               done_s      = 1'b1;
               under_p_s   = under_r;
               under_s     = 1'b0;
               last_in_s   = 1'b0;
               hold_full_s = 1'b0;
               hold_last_s = 1'b0;
            end else if (tick_s) begin
               bit_s = bit_r + 7'd1;
            end else begin
               bit_s = bit_r;
            end
         end
         ST_PREAMBLE, ST_SOP, ST_DATA, ST_EOP: begin
            if (tx_abort) begin
               state_s     = ST_TAIL;
               datao_s     = 1'b0;
               cnt_s       = div_r;
               half_s      = 1'b0;
               bit_s       = 7'd0;
               under_s     = 1'b0;
               hold_full_s = 1'b0;
               hold_last_s = 1'b0;
            end else if (tick_s && !half_r) begin
               half_s  = 1'b1;
               datao_s = cur_bit_s ? ~datao_r : datao_r;
            end else if (tick_s) begin
               // Bit boundary: every bit starts with a transition
               half_s  = 1'b0;
               datao_s = ~datao_r;
               bit_s   = bit_r + 7'd1;
               case (state_r)
                  ST_PREAMBLE: begin
                     if (bit_r == PRE_LAST) begin
                        state_s = ST_SOP;
                        bit_s   = 7'd0;
                     end else begin
                        state_s = ST_PREAMBLE;
                     end
                  end
                  ST_SOP: begin
                     sh_s  = {1'b0, sh_r[19:1]};
                     bnd_s = (bit_r == SOP_LAST);
                  end
                  ST_DATA: begin
                     if (bit_r == 7'd4) begin
                        sh_s = {15'd0, sym_s};
                     end else begin
                        sh_s = {1'b0, sh_r[19:1]};
                     end
                     bnd_s = (bit_r == 7'd9);
                  end
                  ST_EOP: begin
                     sh_s = {1'b0, sh_r[19:1]};
                     if (bit_r == 7'd4) begin
                        state_s = ST_TAIL;
                        datao_s = 1'b0;
                        bit_s   = 7'd0;
                     end else begin
                        state_s = ST_EOP;
                     end
                  end
                  default: state_s = ST_IDLE;
               endcase
            end else begin
               half_s = half_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (bnd_s && avail_s) begin
         state_s     = ST_DATA;
         bit_s       = 7'd0;
         sh_s        = {15'd0, sym_s};
         nib_hi_s    = byte_s[7:4];
         last_in_s   = byte_last_s;
         hold_full_s = 1'b0;
         hold_last_s = 1'b0;
      end else if (bnd_s) begin
         state_s = ST_EOP;
         bit_s   = 7'd0;
         sh_s    = {15'd0, K_EOP};
         under_s = ~last_in_r;
      end else begin
         under_s = under_s;
      end

      ready_s = busy_s & ~hold_full_s & ~last_in_s &
                ((state_s == ST_PREAMBLE) | (state_s == ST_SOP) | (state_s == ST_DATA));
   end

   // State and output registers
   always_ff @(posedge ucpd_clk) begin
      if (!ucpd_rstn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {DIV_W{1'b0}};
         div_r       <= {DIV_W{1'b0}};
         half_r      <= 1'b0;
         bit_r       <= 7'd0;
         sh_r        <= 20'd0;
         nib_hi_r    <= 4'd0;
         hold_r      <= 8'd0;
         hold_last_r <= 1'b0;
         hold_full_r <= 1'b0;
         last_in_r   <= 1'b0;
         under_r     <= 1'b0;
         datao_r     <= 1'b0;
         oen_r       <= 1'b0;
         busy_r      <= 1'b0;
         ready_r     <= 1'b0;
         done_r      <= 1'b0;
         under_p_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         div_r       <= div_s;
         half_r      <= half_s;
         bit_r       <= bit_s;
         sh_r        <= sh_s;
         nib_hi_r    <= nib_hi_s;
         hold_r      <= hold_s;
         hold_last_r <= hold_last_s;
         hold_full_r <= hold_full_s;
         last_in_r   <= last_in_s;
         under_r     <= under_s;
         datao_r     <= datao_s;
         oen_r       <= oen_s;
         busy_r      <= busy_s;
         ready_r     <= ready_s;
         done_r      <= done_s;
         under_p_r   <= under_p_s;
      end
   end

   assign tx_ready    = ready_r;
   assign tx_busy     = busy_r;
   assign tx_done     = done_r;
   assign tx_underrun = under_p_r;
   assign cc_datao    = datao_r;
   assign cc_dataoen  = oen_r;

endmodule

// File: tb/tb_ucpd_bmc_tx.sv
// Directed bench for ucpd_bmc_tx: captures the line per clock, decodes BMC
// and compares against a bit stream built from hand-entered 4b5b tables.
module tb_ucpd_bmc_tx;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] hbit_div = 8'd1;
   logic       tx_start = 1'b0;
   logic [19:0] tx_sop = 20'd0;
   logic [7:0] tx_data = 8'd0;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready;
   logic       tx_abort = 1'b0;
   logic       tx_busy, tx_done, tx_underrun, cc_datao, cc_dataoen;

   always #5 clk = ~clk;

   ucpd_bmc_tx #(.PRE_BITS(64), .TAIL_HB(2), .DIV_W(8)) dut (
      .ucpd_clk(clk), .ucpd_rstn(rstn), .hbit_div(hbit_div), .tx_start(tx_start),
      .tx_sop(tx_sop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .tx_abort(tx_abort), .tx_busy(tx_busy), .tx_done(tx_done),
      .tx_underrun(tx_underrun), .cc_datao(cc_datao), .cc_dataoen(cc_dataoen)
   );

   logic [4:0] enc_tbl [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                5'b11010, 5'b11011, 5'b11100, 5'b11101};
   logic [19:0] sop_sync = {5'b10001, 5'b11000, 5'b11000, 5'b11000};
   logic [19:0] sop_rst  = {5'b11001, 5'b00111, 5'b00111, 5'b00111};

   int         n_cmp = 0, n_bad = 0;
   logic       lv_q[$];
   logic       exp_q[$];
   logic [7:0] feed_b [4];
   int         oen_len, done_cnt, under_cnt;
   logic [1:0] done_lines;
   logic       done_after;
   logic [5:0] rst_outs;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic build_exp(input logic [19:0] sop, input int nbytes);
      logic [4:0] s;
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(i[0]);
      for (int i = 0; i < 20; i++) exp_q.push_back(sop[i]);
      for (int j = 0; j < nbytes; j++) begin
         s = enc_tbl[feed_b[j][3:0]];
         for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
         s = enc_tbl[feed_b[j][7:4]];
         for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
      end
      s = 5'b01101;
      for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
   endtask

   task automatic capture(input int budget, input int abort_at, input int start_at,
                          input int rst_at, input int div_at);
      lv_q.delete();
      oen_len = 0; done_cnt = 0; under_cnt = 0;
      done_lines = 2'b11; done_after = 1'b1; rst_outs = 6'h3f;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (cc_dataoen) begin
            lv_q.push_back(cc_datao);
            oen_len++;
         end
         if (rst_at > 0 && c == rst_at + 1) begin
            rst_outs = {tx_busy, cc_dataoen, cc_datao, tx_ready, tx_done, tx_underrun};
            rstn = 1'b1;
            break;
         end
         if (tx_done) begin
            done_cnt++;
            if (tx_underrun) under_cnt++;
            done_lines = {tx_busy, cc_dataoen};
            @(negedge clk);
            done_after = tx_done;
            break;
         end
         tx_abort = (c == abort_at);
         tx_start = (c == start_at);
         if (c == rst_at) rstn = 1'b0;
         if (c == div_at) hbit_div = 8'd1;
      end
      tx_abort = 1'b0;
      tx_start = 1'b0;
   endtask

   task automatic feed(input int n, input int gap_idx, input int gap_cyc);
      int spin;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         if (i == gap_idx) begin
            for (int g = 0; g < gap_cyc; g++) begin
               if (!tx_busy) break;
               @(negedge clk);
            end
         end
         if (!tx_busy) break;
         tx_data = feed_b[i];
         tx_last = (i == n - 1);
         tx_valid = 1'b1;
         spin = 0;
         while (!tx_ready && tx_busy && spin < 3000) begin
            @(negedge clk);
            spin++;
         end
         if (tx_ready) @(negedge clk);
         tx_valid = 1'b0;
         tx_last = 1'b0;
      end
      tx_valid = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] div, input logic [19:0] sop, input int n,
                            input int gap_idx, input int gap_cyc, input int abort_at,
                            input int start_at, input int rst_at, input int div_at);
      @(negedge clk);
      hbit_div = div;
      tx_sop = sop;
      tx_start = 1'b1;
      fork
         capture(2000, abort_at, start_at, rst_at, div_at);
         feed(n, gap_idx, gap_cyc);
      join
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string name, input int h, input int exp_len, input int exp_under);
      int nb, sz, e_bits, e_tog, e_flat, e_tail, i0, i1;
      logic a, b, prev;
      nb = exp_q.size(); sz = lv_q.size();
      e_bits = 0; e_tog = 0; e_flat = 0; e_tail = 0; prev = 1'b0;
      for (int k = 0; k < nb; k++) begin
         i0 = 2 * k * h;
         i1 = (2 * k + 1) * h;
         if (i1 + h > sz) begin
            e_bits++;
            continue;
         end
         a = lv_q[i0];
         b = lv_q[i1];
         if ((a ^ b) !== exp_q[k]) e_bits++;
         if (a === prev) e_tog++;
         for (int j = 0; j < h; j++)
            if (lv_q[i0 + j] !== a || lv_q[i1 + j] !== b) e_flat++;
         prev = b;
      end
      for (int i = nb * 2 * h; i < sz; i++)
         if (lv_q[i] !== 1'b0) e_tail++;
      check_val({name, ".oen_len"}, oen_len, exp_len);
      check_val({name, ".bits"}, e_bits, 0);
      check_val({name, ".bmc_toggle"}, e_tog, 0);
      check_val({name, ".half_flat"}, e_flat, 0);
      check_val({name, ".tail_low"}, e_tail, 0);
      check_val({name, ".done"}, done_cnt, 1);
      check_val({name, ".underrun"}, under_cnt, exp_under);
      check_val({name, ".done_lines"}, done_lines, 0);
      check_val({name, ".done_1cyc"}, done_after, 0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check_val("reset.outs", {tx_busy, cc_dataoen, cc_datao, tx_ready, tx_done, tx_underrun}, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle.outs", {tx_busy, cc_dataoen, cc_datao, tx_ready, tx_done, tx_underrun}, 0);

      // one byte 00, SYNC SOP, half-bit 2 clocks
      feed_b[0] = 8'h00;
      run_frame(8'd1, sop_sync, 1, -1, 0, -1, -1, -1, -1);
      build_exp(sop_sync, 1);
      check_frame("b00", 2, 400, 0);

      // byte 1F, half-bit 4 clocks, hbit_div disturbed mid-frame
      feed_b[0] = 8'h1F;
      run_frame(8'd3, sop_sync, 1, -1, 0, -1, -1, -1, 50);
      build_exp(sop_sync, 1);
      check_frame("b1f", 4, 800, 0);

      // second byte withheld past the boundary: underrun after byte 1
      feed_b[0] = 8'hAA; feed_b[1] = 8'h55; feed_b[2] = 8'hC3;
      run_frame(8'd1, sop_sync, 3, 1, 500, -1, -1, -1, -1);
      build_exp(sop_sync, 1);
      check_frame("under", 2, 400, 1);

      // abort at the start of preamble bit 30 with a 3-clock half-bit
      run_frame(8'd2, sop_sync, 0, -1, 0, 181, -1, -1, -1);
      check_val("abort.oen_len", oen_len, 187);
      check_val("abort.lvl", (lv_q.size() > 181) ? lv_q[181] : 1'b1, 0);
      check_val("abort.done", done_cnt, 1);
      check_val("abort.underrun", under_cnt, 0);

      // normal frame after the abort, two bytes, RST SOP
      feed_b[0] = 8'h5A; feed_b[1] = 8'h3C;
      run_frame(8'd1, sop_rst, 2, -1, 0, -1, -1, -1, -1);
      build_exp(sop_rst, 2);
      check_frame("post_abort", 2, 440, 0);

      // tx_start while in DATA is ignored
      feed_b[0] = 8'h00;
      run_frame(8'd1, sop_sync, 1, -1, 0, -1, 350, -1, -1);
      build_exp(sop_sync, 1);
      check_frame("restart", 2, 400, 0);

      // reset during SOP
      run_frame(8'd1, sop_sync, 1, -1, 0, -1, -1, 280, -1);
      check_val("rst_mid.outs", rst_outs, 0);
      check_val("rst_mid.done", done_cnt, 0);

      // zero-byte frame
      run_frame(8'd1, sop_sync, 0, -1, 0, -1, -1, -1, -1);
      build_exp(sop_sync, 0);
      check_frame("zero", 2, 360, 1);

      // start together with abort in IDLE does nothing
      @(negedge clk);
      tx_start = 1'b1;
      tx_abort = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_abort = 1'b0;
      check_val("start_abort.busy", {tx_busy, cc_dataoen}, 0);
      @(negedge clk);
      check_val("start_abort.idle", {tx_busy, cc_dataoen, cc_datao}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
